// File: rtl/nbj_pkg.sv
// Shared jump-type encodings and the BTB entry layout for the non-branch jump predictor.
// Entry fields are sized for the widest supported build; instances use the low bits.
package nbj_pkg;

  localparam logic [2:0] NBJ_JALR = 3'd3;
  localparam logic [2:0] NBJ_CALL = 3'd4;
  localparam logic [2:0] NBJ_RET  = 3'd5;

  localparam int NBJ_MAX_XLEN  = 64;
  localparam int NBJ_MAX_TAG_W = 32;

  typedef struct packed {
    logic                     valid;
    logic [NBJ_MAX_TAG_W-1:0] tag;
    logic [NBJ_MAX_XLEN-1:0]  target;
  } btb_entry_t;

endpackage

// File: rtl/nbj_ras.sv
// Circular return-address stack with saturating occupancy and checkpoint restore.
// State updates on the clock edge; top-of-stack read is combinational. No backpressure.
module nbj_ras
  import nbj_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           restore,
  input  logic [XLEN-1:0]                pushData,
  input  logic [$clog2(RAS_DEPTH)-1:0]   restorePtr,
  input  logic [$clog2(RAS_DEPTH+1)-1:0] restoreCnt,
  output logic [$clog2(RAS_DEPTH)-1:0]   ptr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] cnt,
  output logic [XLEN-1:0]                top
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH+1);

  logic [XLEN-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]   ptrInc;

  assign ptrInc = ptr + PW'(1);
  assign top    = stack[ptr];

  // A full stack keeps accepting pushes; the oldest slot is simply overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else if (restore) begin
      ptr <= restorePtr;
      cnt <= restoreCnt;
    end else if (push) begin
      ptr           <= ptrInc;
      stack[ptrInc] <= pushData;
      if (cnt != CW'(RAS_DEPTH)) cnt <= cnt + CW'(1);
    end else if (pop && (cnt != '0)) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/nbj_target_predictor.sv
// Next-PC predictor for direct jumps, JALR, CALL and RET using a tagged BTB and a RAS.
// One registered prediction per fire, one cycle later; flush overrides fire. No backpressure.
module nbj_target_predictor
  import nbj_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RAS_DEPTH   = 8,
  parameter int BTB_ENTRIES = 16,
  parameter int TAG_W       = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_fire,
  input  logic [2:0]                     i_type_3,
  input  logic [XLEN-1:0]                i_instPc_32,
  input  logic [XLEN-1:0]                i_linkPc_32,
  input  logic [XLEN-1:0]                i_jaddr_32,
  input  logic                           i_updValid,
  input  logic [XLEN-1:0]                i_updPc_32,
  input  logic [XLEN-1:0]                i_updTarget_32,
  input  logic                           i_flush,
  input  logic [XLEN-1:0]                i_flushPc_32,
  input  logic [$clog2(RAS_DEPTH)-1:0]   i_flushPtr,
  input  logic [$clog2(RAS_DEPTH+1)-1:0] i_flushCnt,
  output logic                           o_valid,
  output logic [XLEN-1:0]                o_nextPc_32,
  output logic [2:0]                     o_type_3,
  output logic                           o_btbHit,
  output logic                           o_rasEmpty,
  output logic                           o_redirect,
  output logic [$clog2(RAS_DEPTH)-1:0]   o_ptr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] o_cnt
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH+1);

  btb_entry_t      btbMem [BTB_ENTRIES];
  btb_entry_t      updEnt, lkEnt;
  logic [IW-1:0]   lkIdx, updIdx;
  logic [TAG_W-1:0] lkTag, updTag;
  logic            btbHit, predHit, predEmpty, reqFire, rasPush, rasPop;
  logic [XLEN-1:0] pcPlus4, btbTarget, predPc, rasTop;
  logic [PW-1:0]   rasPtr;
  logic [CW-1:0]   rasCnt;
  logic            unusedBits;

  assign lkIdx  = i_instPc_32[IW+1:2];
  assign lkTag  = i_instPc_32[IW+2+TAG_W-1:IW+2];
  assign updIdx = i_updPc_32[IW+1:2];
  assign updTag = i_updPc_32[IW+2+TAG_W-1:IW+2];

  // Training in the same cycle as a lookup of the same slot is visible immediately.
  always_comb begin
    updEnt        = '0;
    updEnt.valid  = 1'b1;
    updEnt.tag    = NBJ_MAX_TAG_W'(updTag);
    updEnt.target = NBJ_MAX_XLEN'(i_updTarget_32);
    lkEnt         = (i_updValid && (updIdx == lkIdx)) ? updEnt : btbMem[lkIdx];
  end

  assign btbHit     = lkEnt.valid && (lkEnt.tag == NBJ_MAX_TAG_W'(lkTag));
  assign pcPlus4    = i_instPc_32 + XLEN'(4);
  assign btbTarget  = btbHit ? lkEnt.target[XLEN-1:0] : pcPlus4;
  assign unusedBits = ^{i_updPc_32, lkEnt.target};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btbMem[i] <= '0;
    end else if (i_updValid) begin
      btbMem[updIdx] <= updEnt;
    end
  end

  assign reqFire = i_fire && !i_flush;
  assign rasPush = reqFire && (i_type_3 == NBJ_CALL);
  assign rasPop  = reqFire && (i_type_3 == NBJ_RET);

  nbj_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push       (rasPush),
    .pop        (rasPop),
    .restore    (i_flush),
    .pushData   (i_linkPc_32),
    .restorePtr (i_flushPtr),
    .restoreCnt (i_flushCnt),
    .ptr        (rasPtr),
    .cnt        (rasCnt),
    .top        (rasTop)
  );

  // A RET on an empty stack falls back to the indirect-target BTB.
  always_comb begin
    predPc    = i_jaddr_32;
    predHit   = 1'b0;
    predEmpty = 1'b0;
    case (i_type_3)
      NBJ_JALR: begin
        predPc  = btbTarget;
        predHit = btbHit;
      end
      NBJ_RET: begin
        if (rasCnt != '0) begin
          predPc = rasTop;
        end else begin
          predPc    = btbTarget;
          predHit   = btbHit;
          predEmpty = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid     <= 1'b0;
      o_nextPc_32 <= '0;
      o_type_3    <= '0;
      o_btbHit    <= 1'b0;
      o_rasEmpty  <= 1'b0;
      o_redirect  <= 1'b0;
      o_ptr       <= '0;
      o_cnt       <= '0;
    end else if (i_flush) begin
      o_valid     <= 1'b1;
      o_nextPc_32 <= i_flushPc_32;
      o_type_3    <= '0;
      o_btbHit    <= 1'b0;
      o_rasEmpty  <= 1'b0;
      o_redirect  <= 1'b1;
      o_ptr       <= rasPtr;
      o_cnt       <= rasCnt;
    end else if (i_fire) begin
      o_valid     <= 1'b1;
      o_nextPc_32 <= predPc;
      o_type_3    <= i_type_3;
      o_btbHit    <= predHit;
      o_rasEmpty  <= predEmpty;
      o_redirect  <= 1'b0;
      o_ptr       <= rasPtr;
      o_cnt       <= rasCnt;
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nbj_target_predictor.sv
// Vector table plus hand sequences for nbj_target_predictor; expectations queued at drive time.
module tb_nbj_target_predictor;

  localparam logic [2:0] JALR = 3'd3;
  localparam logic [2:0] CALL = 3'd4;
  localparam logic [2:0] RET  = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_fire, i_updValid, i_flush;
  logic [2:0]  i_type_3;
  logic [31:0] i_instPc_32, i_linkPc_32, i_jaddr_32, i_updPc_32, i_updTarget_32, i_flushPc_32;
  logic [2:0]  i_flushPtr;
  logic [3:0]  i_flushCnt;
  logic        o_valid, o_btbHit, o_rasEmpty, o_redirect;
  logic [31:0] o_nextPc_32;
  logic [2:0]  o_type_3, o_ptr;
  logic [3:0]  o_cnt;

  typedef struct packed {
    logic        fire, flush, upd;
    logic [2:0]  typ;
    logic [31:0] pc, link, jaddr, updPc, updTgt, flushPc;
    logic [2:0]  fPtr;
    logic [3:0]  fCnt;
    logic        eValid, eHit, eEmpty, eRedir, eRasChk;
    logic [31:0] eNext;
    logic [2:0]  eType, ePtr;
    logic [3:0]  eCnt;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;
  int   seq = 0;

  nbj_target_predictor dut (
    .clk(clk), .rst(rst), .i_fire(i_fire), .i_type_3(i_type_3),
    .i_instPc_32(i_instPc_32), .i_linkPc_32(i_linkPc_32), .i_jaddr_32(i_jaddr_32),
    .i_updValid(i_updValid), .i_updPc_32(i_updPc_32), .i_updTarget_32(i_updTarget_32),
    .i_flush(i_flush), .i_flushPc_32(i_flushPc_32), .i_flushPtr(i_flushPtr),
    .i_flushCnt(i_flushCnt), .o_valid(o_valid), .o_nextPc_32(o_nextPc_32),
    .o_type_3(o_type_3), .o_btbHit(o_btbHit), .o_rasEmpty(o_rasEmpty),
    .o_redirect(o_redirect), .o_ptr(o_ptr), .o_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (item %0d): got 0x%h expected 0x%h", nm, seq, act, exp);
    end
  endtask

  function automatic vec_t vIdle();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t vf(input logic [2:0] typ, input logic [31:0] pc, link, jaddr, eNext,
                              input logic eHit, eEmpty, input logic [2:0] ePtr,
                              input logic [3:0] eCnt);
    vec_t v;
    v = '0;
    v.fire = 1'b1; v.typ = typ; v.pc = pc; v.link = link; v.jaddr = jaddr;
    v.eValid = 1'b1; v.eNext = eNext; v.eType = typ; v.eHit = eHit; v.eEmpty = eEmpty;
    v.ePtr = ePtr; v.eCnt = eCnt; v.eRasChk = 1'b1;
    return v;
  endfunction

  function automatic vec_t withUpd(input vec_t vin, input logic [31:0] pc, tgt);
    vec_t v;
    v = vin;
    v.upd = 1'b1; v.updPc = pc; v.updTgt = tgt;
    return v;
  endfunction

  // Flush with a CALL presented alongside it; the CALL must leave no trace.
  function automatic vec_t vFlush(input logic [31:0] fpc, input logic [2:0] p, input logic [3:0] c);
    vec_t v;
    v = '0;
    v.fire = 1'b1; v.typ = CALL; v.pc = 32'h40; v.link = 32'hDEAD; v.jaddr = 32'h50;
    v.flush = 1'b1; v.flushPc = fpc; v.fPtr = p; v.fCnt = c;
    v.eValid = 1'b1; v.eRedir = 1'b1; v.eNext = fpc; v.eType = 3'd0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    i_fire = v.fire; i_type_3 = v.typ; i_instPc_32 = v.pc; i_linkPc_32 = v.link;
    i_jaddr_32 = v.jaddr; i_updValid = v.upd; i_updPc_32 = v.updPc; i_updTarget_32 = v.updTgt;
    i_flush = v.flush; i_flushPc_32 = v.flushPc; i_flushPtr = v.fPtr; i_flushCnt = v.fCnt;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    sb.push_back(v);
  endtask

  task automatic chkAllZero(input string tagName);
    chk({tagName, " valid"},    32'(o_valid), 32'd0);
    chk({tagName, " nextPc"},   o_nextPc_32, 32'd0);
    chk({tagName, " type"},     32'(o_type_3), 32'd0);
    chk({tagName, " btbHit"},   32'(o_btbHit), 32'd0);
    chk({tagName, " rasEmpty"}, 32'(o_rasEmpty), 32'd0);
    chk({tagName, " redirect"}, 32'(o_redirect), 32'd0);
    chk({tagName, " ptr"},      32'(o_ptr), 32'd0);
    chk({tagName, " cnt"},      32'(o_cnt), 32'd0);
  endtask

  initial begin : monitor
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        seq++;
        chk("valid", 32'(o_valid), 32'(e.eValid));
        if (e.eValid) begin
          chk("nextPc", o_nextPc_32, e.eNext);
          chk("type", 32'(o_type_3), 32'(e.eType));
          chk("redirect", 32'(o_redirect), 32'(e.eRedir));
          if (e.eRasChk) begin
            chk("btbHit", 32'(o_btbHit), 32'(e.eHit));
            chk("rasEmpty", 32'(o_rasEmpty), 32'(e.eEmpty));
            chk("ptr", 32'(o_ptr), 32'(e.ePtr));
            chk("cnt", 32'(o_cnt), 32'(e.eCnt));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    tbl.push_back(vIdle());
    tbl.push_back(vf(CALL, 32'h0F0, 32'h100, 32'h500, 32'h500, 0, 0, 3'd0, 4'd0));
    tbl.push_back(vf(CALL, 32'h500, 32'h200, 32'h600, 32'h600, 0, 0, 3'd1, 4'd1));
    tbl.push_back(vf(RET,  32'h600, 0, 0, 32'h200, 0, 0, 3'd2, 4'd2));
    tbl.push_back(vf(RET,  32'h604, 0, 0, 32'h100, 0, 0, 3'd1, 4'd1));
    tbl.push_back(vf(RET,  32'h700, 0, 0, 32'h704, 0, 1, 3'd0, 4'd0));
    tbl.push_back(vf(3'd0, 32'h800, 0, 32'h1234, 32'h1234, 0, 0, 3'd0, 4'd0));
    tbl.push_back(vf(3'd7, 32'h804, 0, 32'h2000, 32'h2000, 0, 0, 3'd0, 4'd0));
    tbl.push_back(vIdle());
    tbl.push_back(withUpd(vIdle(), 32'h1000, 32'h4000));
    tbl.push_back(vf(JALR, 32'h1000, 0, 32'h9999, 32'h4000, 1, 0, 3'd0, 4'd0));
    tbl.push_back(vf(JALR, 32'h1040, 0, 0, 32'h1044, 0, 0, 3'd0, 4'd0));
    tbl.push_back(withUpd(vf(JALR, 32'h2000, 0, 0, 32'h9000, 1, 0, 3'd0, 4'd0), 32'h2000, 32'h9000));
    tbl.push_back(vf(JALR, 32'h1000, 0, 0, 32'h1004, 0, 0, 3'd0, 4'd0));
    tbl.push_back(vf(RET,  32'h2000, 0, 0, 32'h9000, 1, 1, 3'd0, 4'd0));
    tbl.push_back(withUpd(vf(JALR, 32'h3004, 0, 0, 32'h3008, 0, 0, 3'd0, 4'd0), 32'h0004, 32'hAAA0));
    tbl.push_back(vf(JALR, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 0, 3'd0, 4'd0));
    tbl.push_back(vf(CALL, 32'h10, 32'h20, 32'h30, 32'h30, 0, 0, 3'd0, 4'd0));
    tbl.push_back(withUpd(vFlush(32'h8000, 3'd2, 4'd2), 32'h0008, 32'h7777));
    tbl.push_back(vf(RET,  32'h900, 0, 0, 32'h200, 0, 0, 3'd2, 4'd2));
    tbl.push_back(vf(JALR, 32'h0008, 0, 0, 32'h7777, 1, 0, 3'd1, 4'd1));
    tbl.push_back(vIdle());

    rst = 1'b0;
    drive(vIdle());
    #12;
    chkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Asynchronous reset while a prediction is on the outputs.
    apply(vf(CALL, 32'h100, 32'hABC, 32'h300, 32'h300, 0, 0, 3'd1, 4'd1));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chkAllZero("midReset");
    drive(vIdle());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    apply(vf(RET,  32'h40,   0, 0, 32'h44,   0, 1, 3'd0, 4'd0));
    apply(vf(JALR, 32'h2000, 0, 0, 32'h2004, 0, 0, 3'd0, 4'd0));
    apply(vf(JALR, 32'h0008, 0, 0, 32'h000C, 0, 0, 3'd0, 4'd0));

    // Overflow: nine pushes into eight slots, then drain.
    for (int i = 0; i < 9; i++)
      apply(vf(CALL, 32'h100, 32'(16 * (i + 1)), 32'(32'h300 + i), 32'(32'h300 + i), 0, 0,
               3'(i), (i < 8) ? 4'(i) : 4'd8));
    for (int k = 0; k < 8; k++)
      apply(vf(RET, 32'h700, 0, 0, 32'(32'h90 - 16 * k), 0, 0, 3'(9 - k), 4'(8 - k)));
    apply(vf(RET, 32'h700, 0, 0, 32'h704, 0, 1, 3'd1, 4'd0));
    apply(vIdle());

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected results never produced, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
